// File: rtl/cpu_pkg.sv
// Shared definitions for the fetch front end.
//   PC_W / INSTR_W : word-address and instruction widths
//   BUBBLE         : instruction word presented when valid_ex is low
//   fetch_state_t  : sequencer state, encoded RUN=0 STALL=1 FLUSH=2 HALT=3
//   pc_inc()       : next sequential word address, wrapping silently
package cpu_pkg;

  localparam int PC_W    = 12;
  localparam int INSTR_W = 32;

  localparam logic [INSTR_W-1:0] BUBBLE = 32'h0;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2,
    HALT  = 2'd3
  } fetch_state_t;

  // The top address rolls over to zero; no overflow indication is wanted.
  function automatic logic [PC_W-1:0] pc_inc(input logic [PC_W-1:0] pc);
    return pc + PC_W'(1);
  endfunction

endpackage

// File: rtl/instret_counter.sv
// Retired-instruction counter.
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset, clears the count
//   inc   : add one to the count on this edge
//   count : running total, wraps modulo 2^32
module instret_counter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inc,
  output logic [31:0] count
);

  logic [31:0] count_q;
  logic [31:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc) count_d = count_q + 32'd1;
  end

  // NOTE: state is updated with non-blocking assignments so every flop in the
  // design samples its inputs from the same pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch sequencer: drives the instruction fetch address, holds the instruction
// under execution, and reacts to stall / redirect / halt requests from EX.
//   clk, rst_n      : clock, synchronous active-low reset
//   stall_req       : EX needs another cycle (only honoured while valid_ex=1)
//   redirect_valid  : EX changes flow to redirect_pc (only while valid_ex=1)
//   redirect_pc     : word address of the redirect target
//   halt_req        : EX halts after it completes (only while valid_ex=1)
//   resume          : leave HALT
//   inst_rdata      : instruction memory read data for inst_addr
//   inst_addr       : fetch word address (the internal pc)
//   instr_ex, pc_ex : instruction held for execute and its address
//   valid_ex        : instr_ex is a real instruction, 0 = bubble
//   state           : RUN / STALL / FLUSH / HALT
//   instret         : retired-instruction count
module fetch_sequencer
  import cpu_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall_req,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_pc,
  input  logic               halt_req,
  input  logic               resume,
  input  logic [INSTR_W-1:0] inst_rdata,
  output logic [PC_W-1:0]    inst_addr,
  output logic [INSTR_W-1:0] instr_ex,
  output logic [PC_W-1:0]    pc_ex,
  output logic               valid_ex,
  output logic [1:0]         state,
  output logic [31:0]        instret
);

  fetch_state_t       state_q,    state_d;
  logic [PC_W-1:0]    pc_q,       pc_d;
  logic [INSTR_W-1:0] instr_ex_q, instr_ex_d;
  logic [PC_W-1:0]    pc_ex_q,    pc_ex_d;
  logic               valid_ex_q, valid_ex_d;
  logic               advance;
  logic               retire;

  // EX requests only mean something while a real instruction sits in EX,
  // which can only happen in RUN or STALL.
  logic ex_live;
  assign ex_live = valid_ex_q && ((state_q == RUN) || (state_q == STALL));

  // Any edge that lets a live instruction leave EX retires it, whether it
  // is followed by an advance, a redirect or a halt.
  assign retire = ex_live && !stall_req;

  always_comb begin
    // NOTE: every signal gets a default before the case so that no path
    // leaves it unassigned, which would infer a latch.
    state_d    = state_q;
    pc_d       = pc_q;
    instr_ex_d = instr_ex_q;
    pc_ex_d    = pc_ex_q;
    valid_ex_d = valid_ex_q;
    advance    = 1'b0;

    unique case (state_q)
      RUN, STALL: begin
        if (ex_live && stall_req) begin
          // Freeze everything; redirect and halt wait until the stall drops.
          state_d = STALL;
        end else if (ex_live && halt_req) begin
          // A redirect in the same cycle still decides where we restart.
          state_d    = HALT;
          valid_ex_d = 1'b0;
          instr_ex_d = BUBBLE;
          if (redirect_valid) pc_d = redirect_pc;
        end else if (ex_live && redirect_valid) begin
          // The word fetched this cycle is on the wrong path: drop it and
          // spend one cycle fetching from the target.
          state_d    = FLUSH;
          pc_d       = redirect_pc;
          valid_ex_d = 1'b0;
          instr_ex_d = BUBBLE;
        end else begin
          advance = 1'b1;
        end
      end
      FLUSH:   advance = 1'b1;
      HALT:    advance = resume;
      default: advance = 1'b1;
    endcase

    if (advance) begin
      state_d    = RUN;
      instr_ex_d = inst_rdata;
      pc_ex_d    = pc_q;
      valid_ex_d = 1'b1;
      pc_d       = pc_inc(pc_q);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= RUN;
      pc_q       <= '0;
      instr_ex_q <= BUBBLE;
      pc_ex_q    <= '0;
      valid_ex_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_ex_q <= instr_ex_d;
      pc_ex_q    <= pc_ex_d;
      valid_ex_q <= valid_ex_d;
    end
  end

  instret_counter u_instret (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (retire),
    .count (instret)
  );

  assign inst_addr = pc_q;
  assign instr_ex  = instr_ex_q;
  assign pc_ex     = pc_ex_q;
  assign valid_ex  = valid_ex_q;
  assign state     = state_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer. A driver applies directed then random
// stimulus on the falling edge, advances a behavioural model of the fetch
// rules and queues the expected post-edge outputs; a monitor pops one entry
// after every rising edge and compares it with the DUT.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall_req;
  logic        redirect_valid;
  logic [11:0] redirect_pc;
  logic        halt_req;
  logic        resume;
  logic [31:0] inst_rdata;
  logic [11:0] inst_addr;
  logic [31:0] instr_ex;
  logic [11:0] pc_ex;
  logic        valid_ex;
  logic [1:0]  state;
  logic [31:0] instret;

  always #5 clk = ~clk;

  // Instruction ROM: mem[i] = i + 100.
  assign inst_rdata = 32'(inst_addr) + 32'd100;

  fetch_sequencer dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall_req      (stall_req),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt_req       (halt_req),
    .resume         (resume),
    .inst_rdata     (inst_rdata),
    .inst_addr      (inst_addr),
    .instr_ex       (instr_ex),
    .pc_ex          (pc_ex),
    .valid_ex       (valid_ex),
    .state          (state),
    .instret        (instret)
  );

  typedef struct {
    int unsigned state;
    int unsigned addr;
    int unsigned instr;
    int unsigned pcex;
    int unsigned valid;
    int unsigned instret;
  } snap_t;

  snap_t exp_q[$];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s @%0t: got %0d, expected %0d", name, $time, act, req);
  endtask

  // Behavioural model: a mode number plus plain integers.
  // Modes: 0 running, 1 stalled, 2 flushing, 3 halted.
  int unsigned m_mode, m_pc, m_instr, m_pcex, m_valid, m_instret;

  function automatic void model_step(input bit r, s, rv, input int unsigned rp,
                                     input bit h, rs);
    bit fetch_now;
    fetch_now = 0;
    if (!r) begin
      m_mode = 0; m_pc = 0; m_instr = 0; m_pcex = 0; m_valid = 0; m_instret = 0;
      return;
    end
    if (m_mode == 3) begin
      fetch_now = rs;
    end else if (m_mode == 2) begin
      fetch_now = 1;
    end else if (m_valid == 1 && s) begin
      m_mode = 1;                        // everything frozen
    end else begin
      if (m_valid == 1) m_instret = (m_instret + 1) % 33'h1_0000_0000;
      if (m_valid == 1 && h) begin
        if (rv) m_pc = rp;
        m_valid = 0; m_instr = 0; m_mode = 3;
      end else if (m_valid == 1 && rv) begin
        m_pc = rp; m_valid = 0; m_instr = 0; m_mode = 2;
      end else begin
        fetch_now = 1;
      end
    end
    if (fetch_now) begin
      m_instr = m_pc + 100;
      m_pcex  = m_pc;
      m_valid = 1;
      m_pc    = (m_pc + 1) % 4096;
      m_mode  = 0;
    end
  endfunction

  task automatic cycle(input bit r, s, rv, input int unsigned rp, input bit h, rs);
    snap_t e;
    @(negedge clk);
    rst_n = r; stall_req = s; redirect_valid = rv; redirect_pc = 12'(rp);
    halt_req = h; resume = rs;
    model_step(r, s, rv, rp, h, rs);
    e.state = m_mode; e.addr = m_pc; e.instr = m_instr;
    e.pcex = m_pcex; e.valid = m_valid; e.instret = m_instret;
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1, 0, 0, 0, 0, 0);
  endtask

  // Monitor: one snapshot per rising edge, sampled 1 time unit after it.
  initial begin
    snap_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("state",     32'(state),     e.state);
        check("inst_addr", 32'(inst_addr), e.addr);
        check("pc_ex",     32'(pc_ex),     e.pcex);
        check("valid_ex",  32'(valid_ex),  e.valid);
        check("instr_ex",  instr_ex,       e.instr);
        check("instret",   instret,        e.instret);
      end
    end
  end

  initial begin
    rst_n = 0; stall_req = 0; redirect_valid = 0; redirect_pc = '0;
    halt_req = 0; resume = 0;

    // Reset, then five edges of straight-line fetch from address 0.
    cycle(0, 0, 0, 0, 0, 0);
    cycle(0, 1, 1, 9, 1, 1);             // reset overrides every other input
    idle(5);

    // Stall for three cycles while pc_ex=2, then release.
    cycle(0, 0, 0, 0, 0, 0);
    idle(3);
    for (int i = 0; i < 3; i++) cycle(1, 1, 1, 99, 1, 0);
    idle(3);                             // pc_ex reaches 5

    // Redirect to 40, then the single bubble and the refetch.
    cycle(1, 0, 1, 40, 0, 0);
    idle(2);

    // Halt with a simultaneous redirect to 7; hold ten cycles, then resume.
    cycle(1, 0, 1, 7, 1, 0);
    for (int i = 0; i < 10; i++) cycle(1, 1, 1, 300, 1, 0);
    cycle(1, 0, 0, 0, 0, 1);
    idle(2);

    // Wrap of the fetch address at 4095.
    cycle(1, 0, 1, 4094, 0, 0);
    idle(4);

    // Build instret up to 9, stall, and reset in the middle of the stall.
    cycle(0, 0, 0, 0, 0, 0);
    idle(10);                            // instret = 9 after the tenth edge
    cycle(1, 1, 0, 0, 0, 0);
    cycle(1, 1, 0, 0, 0, 0);
    cycle(0, 1, 0, 0, 0, 0);
    idle(2);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      bit r, s, rv, h, rs;
      int unsigned rp;
      r  = ($urandom_range(99) >= 2);
      s  = ($urandom_range(99) < 20);
      rv = ($urandom_range(99) < 12);
      h  = ($urandom_range(99) < 5);
      rs = ($urandom_range(99) < 30);
      rp = ($urandom_range(3) == 0) ? 4093 + $urandom_range(2) : $urandom_range(4095);
      cycle(r, s, rv, rp, h, rs);
    end

    // Let the monitor drain; a stuck queue counts as a failure.
    begin
      int budget;
      budget = 20;
      while (exp_q.size() > 0 && budget > 0) begin
        @(posedge clk);
        budget--;
      end
      @(negedge clk);
      n_checks++;
      if (exp_q.size() == 0) n_pass++;
      else $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 SHALL have port clk  input  1  rising-edge clock.
REQ-002 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-003 SHALL have port stall_req  input  1  EX stage needs another cycle; valid only while valid_ex=1.
REQ-004 SHALL have port redirect_valid  input  1  EX instruction changes flow (branch/jump); valid only while valid_ex=1.
REQ-005 SHALL have port redirect_pc  input  12  word address of redirect target.
REQ-006 SHALL have port halt_req  input  1  EX instruction requests halt after it completes; valid only while valid_ex=1.
REQ-007 SHALL have port resume  input  1  leave HALT; ignored in other states.
REQ-008 SHALL have port inst_rdata  input  32  instruction word at inst_addr, combinational read.
REQ-009 SHALL have port inst_addr  output  12  fetch word address, equal to internal pc.
REQ-010 SHALL have port instr_ex  output  32  instruction held for decode/execute.
REQ-011 SHALL have port pc_ex  output  12  word address of instr_ex.
REQ-012 SHALL have port valid_ex  output  1  instr_ex is a real instruction (0 = bubble).
REQ-013 SHALL have port state  output  2  RUN=0, STALL=1, FLUSH=2, HALT=3.
REQ-014 SHALL have port instret  output  32  retired-instruction count.

Function
REQ-015 Advance: in RUN with valid_ex=0, or valid_ex=1 and no stall/redirect/halt, SHALL on the edge set instr_ex<=inst_rdata, pc_ex<=pc, valid_ex<=1, pc<=pc+1.
REQ-016 pc+1 SHALL wrap 4095 -> 0 with no flag.
REQ-017 Priority when valid_ex=1: stall_req > halt_req > redirect_valid > advance.
REQ-018 stall_req=1 with valid_ex=1 SHALL hold pc, instr_ex, pc_ex, valid_ex, instret; state -> STALL; remain STALL while stall_req=1; redirect_valid/halt_req ignored while stall_req=1.
REQ-019 STALL with stall_req=0 SHALL evaluate halt/redirect/advance exactly as RUN on that edge.
REQ-020 Retire: an edge where valid_ex=1 and stall_req=0 SHALL increment instret by 1 (mod 2^32).
REQ-021 redirect_valid=1 (no stall, no halt) SHALL set pc<=redirect_pc, instr_ex<=32'h0, valid_ex<=0, state -> FLUSH.
REQ-022 FLUSH SHALL last exactly one cycle: next edge performs an advance from redirect_pc, state -> RUN; one bubble per redirect.
REQ-023 halt_req=1 (no stall) SHALL set valid_ex<=0, instr_ex<=32'h0, state -> HALT; pc<=redirect_pc if redirect_valid=1 same cycle, else pc<=pc (next sequential address).
REQ-024 HALT SHALL hold pc, outputs and instret until resume=1; the resume edge performs an advance, state -> RUN.
REQ-025 In FLUSH and HALT, stall_req, redirect_valid, halt_req SHALL be ignored.
REQ-026 inst_addr SHALL equal pc combinationally at all times.

Reset
REQ-027 rst_n=0 on an edge SHALL set pc=0, instr_ex=32'h0, pc_ex=0, valid_ex=0, instret=0, state=RUN, overriding all other inputs in any state.
REQ-028 First edge after rst_n rises SHALL fetch address 0 (instr_ex<=mem[0], pc<=1).

Structure
REQ-029 Shared package cpu_pkg SHALL hold PC_W=12, INSTR_W=32, BUBBLE=32'h0 and enum fetch_state_t {RUN, STALL, FLUSH, HALT} with the REQ-013 encoding.
REQ-030 Retire counting SHALL be a sub-module instret_counter (clk, rst_n, inc, count[31:0]); all other logic in fetch_sequencer.

Verification
REQ-031 Reset then 5 edges, ROM mem[i]=i+100 -> pc_ex=0..4, instr_ex=100..104, valid_ex=1, instret=4 after edge 5.
REQ-032 stall_req=1 for 3 cycles with pc_ex=2 -> state=STALL, pc_ex=2, inst_addr=3 held, instret unchanged; after release advances to pc_ex=3.
REQ-033 redirect_valid=1, redirect_pc=40 at pc_ex=5 -> next cycle valid_ex=0, state=FLUSH, inst_addr=40; following cycle pc_ex=40, valid_ex=1, instret +1 total.
REQ-034 halt_req=1 with redirect_valid=1, redirect_pc=7 -> state=HALT, valid_ex=0, inst_addr=7 held 10 cycles; resume=1 -> pc_ex=7, state=RUN.
REQ-035 pc at 4095 advance -> pc_ex=4095, inst_addr=0; then pc_ex=0.
REQ-036 rst_n=0 during STALL with instret=9 -> next cycle all outputs at REQ-027 values, state=RUN.
